// File: rtl/rom_scale_copier.sv
// Copies a SRC_W x SRC_H image from the synchronous ROM into the framebuffer,
// enlarged by an integer nearest-neighbour factor chosen at start time.
module rom_scale_copier #(
   parameter int SRC_W      = 160,
   parameter int SRC_H      = 120,
   parameter int MAX_FACTOR = 4,
   parameter int DST_STRIDE = 640,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        factor,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [9:0]        out_w,
   output logic [9:0]        out_h,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] ram_wraddr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren
);

   localparam int SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
   localparam int SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        fm1_q, fm1_d;
   logic [2:0]        hsub_q, hsub_d;
   logic [2:0]        vsub_q, vsub_d;
   logic [SX_W-1:0]   sx_q, sx_d;
   logic [SY_W-1:0]   sy_q, sy_d;
   logic [ADDR_W-1:0] src_row_base_q, src_row_base_d;
   logic [ADDR_W-1:0] dst_row_base_q, dst_row_base_d;
   logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] ram_wraddr_q, ram_wraddr_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ram_wren_q, ram_wren_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [9:0]        out_w_q, out_w_d;
   logic [9:0]        out_h_q, out_h_d;

   logic factor_ok;
   logic hsub_end, vsub_end, sx_end, sy_end;

   assign factor_ok = (factor != 3'd0) && (factor <= 3'(MAX_FACTOR));
   assign hsub_end  = (hsub_q == fm1_q);
   assign vsub_end  = (vsub_q == fm1_q);
   assign sx_end    = (sx_q == SX_W'(SRC_W - 1));
   assign sy_end    = (sy_q == SY_W'(SRC_H - 1));

   always_comb begin
      state_d        = state_q;
      fm1_d          = fm1_q;
      hsub_d         = hsub_q;
      vsub_d         = vsub_q;
      sx_d           = sx_q;
      sy_d           = sy_q;
      src_row_base_d = src_row_base_q;
      dst_row_base_d = dst_row_base_q;
      dst_addr_d     = dst_addr_q;
      rom_addr_d     = rom_addr_q;
      rd_valid_d     = 1'b0;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      err_d          = 1'b0;
      out_w_d        = out_w_q;
      out_h_d        = out_h_q;
      ram_wren_d     = rd_valid_q;
      ram_wraddr_d   = rd_valid_q ? dst_addr_q : ram_wraddr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (factor_ok) begin
                  state_d        = RUN;
                  fm1_d          = factor - 3'd1;
                  out_w_d        = 10'(SRC_W) * 10'(factor);
                  out_h_d        = 10'(SRC_H) * 10'(factor);
                  hsub_d         = '0;
                  vsub_d         = '0;
                  sx_d           = '0;
                  sy_d           = '0;
                  src_row_base_d = '0;
                  dst_row_base_d = '0;
                  dst_addr_d     = '0;
                  rom_addr_d     = '0;
                  rd_valid_d     = 1'b1;
                  busy_d         = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            busy_d = 1'b1;
            if (hsub_end && vsub_end && sx_end && sy_end) begin
               state_d = FLUSH;
            end else begin
               rd_valid_d = 1'b1;
               hsub_d     = hsub_q + 3'd1;
               dst_addr_d = dst_addr_q + 1'b1;
               if (hsub_end) begin
                  hsub_d = '0;
                  if (sx_end) begin
                     // Destination row finished: either replay this source row or move on.
                     sx_d           = '0;
                     dst_row_base_d = dst_row_base_q + ADDR_W'(DST_STRIDE);
                     dst_addr_d     = dst_row_base_q + ADDR_W'(DST_STRIDE);
                     if (vsub_end) begin
                        vsub_d         = '0;
                        sy_d           = sy_q + 1'b1;
                        src_row_base_d = src_row_base_q + ADDR_W'(SRC_W);
                        rom_addr_d     = src_row_base_q + ADDR_W'(SRC_W);
                     end else begin
                        vsub_d     = vsub_q + 3'd1;
                        rom_addr_d = src_row_base_q;
                     end
                  end else begin
                     sx_d       = sx_q + 1'b1;
                     rom_addr_d = rom_addr_q + 1'b1;
                  end
               end
            end
         end
         FLUSH: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         fm1_q          <= '0;
         hsub_q         <= '0;
         vsub_q         <= '0;
         sx_q           <= '0;
         sy_q           <= '0;
         src_row_base_q <= '0;
         dst_row_base_q <= '0;
         dst_addr_q     <= '0;
         rom_addr_q     <= '0;
         ram_wraddr_q   <= '0;
         rd_valid_q     <= 1'b0;
         ram_wren_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         out_w_q        <= '0;
         out_h_q        <= '0;
      end else begin
         state_q        <= state_d;
         fm1_q          <= fm1_d;
         hsub_q         <= hsub_d;
         vsub_q         <= vsub_d;
         sx_q           <= sx_d;
         sy_q           <= sy_d;
         src_row_base_q <= src_row_base_d;
         dst_row_base_q <= dst_row_base_d;
         dst_addr_q     <= dst_addr_d;
         rom_addr_q     <= rom_addr_d;
         ram_wraddr_q   <= ram_wraddr_d;
         rd_valid_q     <= rd_valid_d;
         ram_wren_q     <= ram_wren_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
         out_w_q        <= out_w_d;
         out_h_q        <= out_h_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign out_w      = out_w_q;
   assign out_h      = out_h_q;
   assign rom_addr   = rom_addr_q;
   assign ram_wraddr = ram_wraddr_q;
   assign ram_wren   = ram_wren_q;
   assign ram_data   = rom_data;

endmodule
